mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port synchronous data RAM (MEMSTAGE) between the processor data path and a DMA/program-loader port. It sits between the processor's memory-address/data signals and the RAM: it grants at most one access per cycle, steers address/data/write-enable to the RAM and routes the read data back to the requester with a one-cycle-later valid strobe. CPU has priority by default. A starvation counter guarantees the DMA port forward progress.

---
 rtl/mem_arbiter.sv | 100 ++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter: shares one single-port synchronous RAM between CPU and DMA. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int RR_MODE    = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   localparam logic       c_OWNER_CPU  = 1'b0;
   localparam logic       c_OWNER_DMA  = 1'b1;
   localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

   logic [3:0] r_starve_cnt;
   logic       r_last_owner;
   logic       r_rd_pend;
   logic       r_rd_owner;

   logic       w_dma_wins_tie;
   logic       w_cpu_gnt;
   logic       w_dma_gnt;
   logic [3:0] w_starve_nxt;

   always_comb begin
      w_dma_wins_tie = 1'b0;
      if (RR_MODE != 0)
         w_dma_wins_tie = (r_last_owner == c_OWNER_CPU);
      else
         w_dma_wins_tie = (r_starve_cnt >= c_STARVE_MAX);
   end

   always_comb begin
      w_cpu_gnt = cpu_req;
      w_dma_gnt = dma_req;
      if (cpu_req && dma_req) begin
         w_cpu_gnt = !w_dma_wins_tie;
         w_dma_gnt = w_dma_wins_tie;
      end
   end

   // Counter only runs while DMA is actively being denied; saturates at the limit.
   always_comb begin
      w_starve_nxt = 4'd0;
      if (dma_req && !w_dma_gnt)
         w_starve_nxt = (r_starve_cnt >= c_STARVE_MAX) ? c_STARVE_MAX : r_starve_cnt + 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve_cnt <= 4'd0;
         r_last_owner <= c_OWNER_DMA;
         r_rd_pend    <= 1'b0;
         r_rd_owner   <= c_OWNER_CPU;
      end else begin
         r_starve_cnt <= w_starve_nxt;
         if (w_cpu_gnt || w_dma_gnt)
            r_last_owner <= w_dma_gnt ? c_OWNER_DMA : c_OWNER_CPU;
         r_rd_pend  <= (w_cpu_gnt && !cpu_we) || (w_dma_gnt && !dma_we);
         r_rd_owner <= w_dma_gnt ? c_OWNER_DMA : c_OWNER_CPU;
      end
   end

   // Idle cycles leave the CPU address/data on the RAM bus.
   assign mem_we   = w_dma_gnt ? dma_we    : (w_cpu_gnt && cpu_we);
   assign mem_addr = w_dma_gnt ? dma_addr  : cpu_addr;
   assign mem_din  = w_dma_gnt ? dma_wdata : cpu_wdata;

   assign cpu_gnt    = w_cpu_gnt;
   assign dma_gnt    = w_dma_gnt;
   assign cpu_rvalid = r_rd_pend && (r_rd_owner == c_OWNER_CPU);
   assign dma_rvalid = r_rd_pend && (r_rd_owner == c_OWNER_DMA);
   assign cpu_rdata  = cpu_rvalid ? mem_dout : '0;
   assign dma_rdata  = dma_rvalid ? mem_dout : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_arbiter: runs a priority-mode and a round-robin-mode arbiter side |
// | by side on shared stimulus, each with its own RAM. Revision: 1.0         |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;

   localparam int c_STARVE = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [9:0]  cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic        dma_req = 1'b0, dma_we = 1'b0;
   logic [9:0]  dma_addr = '0;
   logic [31:0] dma_wdata = '0;

   logic        d_cpu_gnt[2], d_cpu_rvalid[2], d_dma_gnt[2], d_dma_rvalid[2], d_mem_we[2];
   logic [31:0] d_cpu_rdata[2], d_dma_rdata[2], d_mem_din[2], d_mem_dout[2];
   logic [9:0]  d_mem_addr[2];

   logic [31:0] ram[2][1024];
   logic [31:0] mmem[2][1024];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(c_STARVE), .RR_MODE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(d_cpu_gnt[0]), .cpu_rvalid(d_cpu_rvalid[0]), .cpu_rdata(d_cpu_rdata[0]),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(d_dma_gnt[0]), .dma_rvalid(d_dma_rvalid[0]), .dma_rdata(d_dma_rdata[0]),
      .mem_we(d_mem_we[0]), .mem_addr(d_mem_addr[0]), .mem_din(d_mem_din[0]),
      .mem_dout(d_mem_dout[0])
   );

   mem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(c_STARVE), .RR_MODE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(d_cpu_gnt[1]), .cpu_rvalid(d_cpu_rvalid[1]), .cpu_rdata(d_cpu_rdata[1]),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(d_dma_gnt[1]), .dma_rvalid(d_dma_rvalid[1]), .dma_rdata(d_dma_rdata[1]),
      .mem_we(d_mem_we[1]), .mem_addr(d_mem_addr[1]), .mem_din(d_mem_din[1]),
      .mem_dout(d_mem_dout[1])
   );

   // Read-first synchronous RAM per instance.
   always @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         d_mem_dout[m] <= ram[m][d_mem_addr[m]];
         if (d_mem_we[m]) ram[m][d_mem_addr[m]] <= d_mem_din[m];
      end
   end

   task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[inst %0d]: got %h, expected %h at %0t", name, m, act, exp, $time);
      end
   endtask

   // Model: an access is a (port, we, addr) event; reads return memory as of the grant.
   int          m_denied_run[2];
   logic        m_last_dma[2];
   logic        m_pend[2];
   logic        m_pend_dma[2];
   logic [31:0] m_pend_data[2];
   logic        eg_c, eg_d, ev_c, ev_d;

   initial begin
      for (int m = 0; m < 2; m++) begin
         m_denied_run[m] = 0;
         m_last_dma[m]   = 1'b1;
         m_pend[m]       = 1'b0;
         m_pend_dma[m]   = 1'b0;
         m_pend_data[m]  = '0;
      end
   end

   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (!rst_n) begin
            m_denied_run[m] = 0;
            m_last_dma[m]   = 1'b1;
            m_pend[m]       = 1'b0;
         end
         eg_c = cpu_req;
         eg_d = dma_req;
         if (cpu_req && dma_req) begin
            if (m == 1) eg_d = !m_last_dma[m];
            else        eg_d = (m_denied_run[m] >= c_STARVE);
            eg_c = !eg_d;
         end
         ev_c = m_pend[m] && !m_pend_dma[m];
         ev_d = m_pend[m] && m_pend_dma[m];
         chk("cpu_gnt",    m, 32'(d_cpu_gnt[m]),    32'(eg_c));
         chk("dma_gnt",    m, 32'(d_dma_gnt[m]),    32'(eg_d));
         chk("mem_we",     m, 32'(d_mem_we[m]),     32'(eg_d ? dma_we : (eg_c && cpu_we)));
         chk("mem_addr",   m, 32'(d_mem_addr[m]),   32'(eg_d ? dma_addr : cpu_addr));
         chk("mem_din",    m, d_mem_din[m],         eg_d ? dma_wdata : cpu_wdata);
         chk("cpu_rvalid", m, 32'(d_cpu_rvalid[m]), 32'(ev_c));
         chk("dma_rvalid", m, 32'(d_dma_rvalid[m]), 32'(ev_d));
         chk("cpu_rdata",  m, d_cpu_rdata[m],       ev_c ? m_pend_data[m] : 32'h0);
         chk("dma_rdata",  m, d_dma_rdata[m],       ev_d ? m_pend_data[m] : 32'h0);

         m_pend[m]      = (eg_c && !cpu_we) || (eg_d && !dma_we);
         m_pend_dma[m]  = eg_d;
         m_pend_data[m] = mmem[m][eg_d ? dma_addr : cpu_addr];
         if (eg_d && dma_we)       mmem[m][dma_addr] = dma_wdata;
         else if (eg_c && cpu_we)  mmem[m][cpu_addr] = cpu_wdata;
         if (eg_c || eg_d) m_last_dma[m] = eg_d;
         m_denied_run[m] = (dma_req && !eg_d) ? m_denied_run[m] + 1 : 0;
         if (!rst_n) begin
            m_denied_run[m] = 0;
            m_last_dma[m]   = 1'b1;
            m_pend[m]       = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts cycles on the priority instance until DMA is granted; returns at that negedge.
   task automatic wait_dma0(input int max, output int at, output logic c1,
                            output logic we, output logic [9:0] addr);
      at = 0; c1 = 1'b0; we = 1'b0; addr = '0;
      for (int k = 1; k <= max; k++) begin
         @(negedge clk);
         if (k == 1) c1 = d_cpu_gnt[0];
         if (d_dma_gnt[0]) begin
            at = k; we = d_mem_we[0]; addr = d_mem_addr[0];
            return;
         end
         tick();
      end
   endtask

   int          at;
   logic        c1, gwe;
   logic [9:0]  gaddr;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         ram[0][i]  = 32'h5A5A0000 ^ 32'(i * 7);
         ram[1][i]  = 32'h5A5A0000 ^ 32'(i * 7);
         mmem[0][i] = 32'h5A5A0000 ^ 32'(i * 7);
         mmem[1][i] = 32'h5A5A0000 ^ 32'(i * 7);
      end
      ram[0][5] = 32'hDEADBEEF; ram[1][5] = 32'hDEADBEEF;
      mmem[0][5] = 32'hDEADBEEF; mmem[1][5] = 32'hDEADBEEF;

      // Reset with both ports requesting reads: no rvalid may appear.
      rst_n = 1'b0;
      cpu_req = 1'b1; cpu_addr = 10'h001;
      dma_req = 1'b1; dma_addr = 10'h002;
      repeat (3) begin
         @(negedge clk);
         for (int m = 0; m < 2; m++) begin
            chk("rst_cpu_rvalid", m, 32'(d_cpu_rvalid[m]), 32'h0);
            chk("rst_dma_rvalid", m, 32'(d_dma_rvalid[m]), 32'h0);
         end
      end
      tick();
      rst_n = 1'b1;
      wait_dma0(10, at, c1, gwe, gaddr);
      chk("first_cycle_cpu_gnt", 0, 32'(c1), 32'h1);
      chk("dma_forced_cycle", 0, 32'(at), 32'd5);
      tick();
      cpu_req = 1'b0; dma_req = 1'b0;

      // Lone CPU read of a preloaded word.
      tick();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
      @(negedge clk);
      for (int m = 0; m < 2; m++) chk("lone_cpu_gnt", m, 32'(d_cpu_gnt[m]), 32'h1);
      tick();
      cpu_req = 1'b0;
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         chk("lone_cpu_rvalid", m, 32'(d_cpu_rvalid[m]), 32'h1);
         chk("lone_cpu_rdata",  m, d_cpu_rdata[m], 32'hDEADBEEF);
         chk("lone_dma_rvalid", m, 32'(d_dma_rvalid[m]), 32'h0);
      end

      // DMA write under continuous CPU traffic.
      tick();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 10'h0AA; dma_wdata = 32'h12345678;
      wait_dma0(10, at, c1, gwe, gaddr);
      chk("starved_write_cycle", 0, 32'(at), 32'd5);
      chk("starved_write_we", 0, 32'(gwe), 32'h1);
      chk("starved_write_addr", 0, 32'(gaddr), 32'h0AA);
      tick();
      dma_req = 1'b0; dma_we = 1'b0;
      cpu_addr = 10'h0AA;
      @(negedge clk);
      tick();
      cpu_req = 1'b0;
      @(negedge clk);
      for (int m = 0; m < 2; m++) chk("readback_0AA", m, d_cpu_rdata[m], 32'h12345678);

      // Round robin: last owner is CPU, so the first tie goes to DMA.
      tick();
      cpu_req = 1'b1; cpu_addr = 10'h020;
      dma_req = 1'b1; dma_addr = 10'h030;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("rr_alternate", 1, 32'(d_dma_gnt[1]), 32'((k % 2) == 0));
         tick();
      end
      cpu_req = 1'b0; dma_req = 1'b0;

      // DMA read granted, then reset before its response.
      tick();
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 10'h030;
      @(negedge clk);
      for (int m = 0; m < 2; m++) chk("rst_mid_dma_gnt", m, 32'(d_dma_gnt[m]), 32'h1);
      tick();
      dma_req = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      for (int m = 0; m < 2; m++) chk("rst_mid_rvalid", m, 32'(d_dma_rvalid[m]), 32'h0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      for (int m = 0; m < 2; m++) chk("post_rst_rvalid", m, 32'(d_dma_rvalid[m]), 32'h0);

      // DMA gives up after two denials; a new attempt waits the full limit again.
      tick();
      cpu_req = 1'b1; cpu_addr = 10'h040;
      dma_req = 1'b1; dma_addr = 10'h050;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("abandon_no_dma_gnt", 0, 32'(d_dma_gnt[0]), 32'h0);
         tick();
      end
      dma_req = 1'b0;
      tick();
      tick();
      dma_req = 1'b1;
      wait_dma0(10, at, c1, gwe, gaddr);
      chk("retry_dma_cycle", 0, 32'(at), 32'd5);
      tick();
      cpu_req = 1'b0; dma_req = 1'b0;
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
